// File: rtl/ic_rgbtoycbcr_mcu_sched.sv
// ic_rgbtoycbcr_mcu_sched
//   Read scheduler for the Y/Cb/Cr colour FIFOs of the RGB->YCbCr stage.
//   Issues FIFO reads in JPEG 4:2:0 MCU order (Y0..Y3, Cb, Cr, 8 rows each)
//   and delivers each word with its tags on a valid/ready stream.
// Ports
//   clock, aclr                  clock and async active-high reset
//   enable                       permit start of a new MCU (sampled in IDLE)
//   flush                        abort MCU, drop buffered data, clear FIFOs
//   {y,cb,cr}_empty/_rdreq/_q    non-showahead FIFO read ports
//   ff_sclr                      one-cycle-delayed sync clear to all FIFOs
//   out_valid/out_ready/out_*    tagged output stream (data, comp, blk, row, mcu_last)
//   busy                         MCU in progress or data in flight/buffered
module ic_rgbtoycbcr_mcu_sched #(
  parameter int DATA_W     = 64,
  parameter int ROWS_PER_B = 8,
  parameter int Y_BLOCKS   = 4
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              enable,
  input  logic              flush,
  input  logic              y_empty,
  output logic              y_rdreq,
  input  logic [DATA_W-1:0] y_q,
  input  logic              cb_empty,
  output logic              cb_rdreq,
  input  logic [DATA_W-1:0] cb_q,
  input  logic              cr_empty,
  output logic              cr_rdreq,
  input  logic [DATA_W-1:0] cr_q,
  output logic              ff_sclr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_comp,
  output logic [1:0]        out_blk,
  output logic [2:0]        out_row,
  output logic              out_mcu_last,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_Y, S_CB, S_CR} state_e;

  typedef struct packed {
    logic [1:0] comp;
    logic [1:0] blk;
    logic [2:0] row;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } word_t;

  localparam logic [2:0] ROW_LAST = 3'(ROWS_PER_B - 1);
  localparam logic [1:0] BLK_LAST = 2'(Y_BLOCKS - 1);

  state_e     state_q, state_d;
  logic [1:0] blk_q, blk_d;
  logic [2:0] row_q, row_d;
  logic       if_vld_q, if_vld_d;   // read issued last cycle, q arrives now
  tag_t       if_tag_q, if_tag_d;
  word_t      buf_q [2];            // buf_q[0] is the head
  word_t      buf_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       sclr_q, sclr_d;

  logic       src_empty, credit_ok, issue, pop, push;
  logic [1:0] cur_comp;
  word_t      cap;

  always_comb begin
    src_empty = 1'b1;
    cur_comp  = 2'd0;
    unique case (state_q)
      S_Y:     begin src_empty = y_empty;  cur_comp = 2'd0; end
      S_CB:    begin src_empty = cb_empty; cur_comp = 2'd1; end
      S_CR:    begin src_empty = cr_empty; cur_comp = 2'd2; end
      default: begin src_empty = 1'b1;     cur_comp = 2'd0; end
    endcase
  end

  // Occupancy after this cycle's pop must leave room for one more word;
  // this is what keeps the 2-entry buffer from overflowing.
  assign pop       = (cnt_q != 2'd0) & out_ready;
  assign credit_ok = (({1'b0, cnt_q} + {2'b0, if_vld_q}) - {2'b0, pop}) < 3'd2;
  assign issue     = (state_q != S_IDLE) & ~src_empty & credit_ok & ~flush;
  assign push      = if_vld_q;

  assign y_rdreq  = issue & (state_q == S_Y);
  assign cb_rdreq = issue & (state_q == S_CB);
  assign cr_rdreq = issue & (state_q == S_CR);

  always_comb begin
    cap.tag  = if_tag_q;
    cap.data = y_q;
    unique case (if_tag_q.comp)
      2'd0:    cap.data = y_q;
      2'd1:    cap.data = cb_q;
      default: cap.data = cr_q;
    endcase
  end

  // Issue pointer / FSM next state
  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    row_d         = row_q;
    if_vld_d      = issue;
    if_tag_d.comp = cur_comp;
    if_tag_d.blk  = blk_q;
    if_tag_d.row  = row_q;
    if_tag_d.last = (state_q == S_CR) & (row_q == ROW_LAST);
    sclr_d        = flush;

    if (state_q == S_IDLE) begin
      if (enable & ~flush) state_d = S_Y;
    end else if (issue) begin
      if (row_q == ROW_LAST) begin
        row_d = 3'd0;
        unique case (state_q)
          S_Y: begin
            if (blk_q == BLK_LAST) begin
              blk_d   = 2'd0;
              state_d = S_CB;
            end else begin
              blk_d = blk_q + 2'd1;
            end
          end
          S_CB:    state_d = S_CR;
          default: state_d = S_IDLE;
        endcase
      end else begin
        row_d = row_q + 3'd1;
      end
    end

    if (flush) begin
      state_d  = S_IDLE;
      blk_d    = 2'd0;
      row_d    = 3'd0;
      if_vld_d = 1'b0;
    end
  end

  // Output buffer: shift-style 2-entry FIFO, head always in slot 0
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        buf_d[cnt_q[0]] = cap;
        cnt_d           = cnt_q + 2'd1;
      end
      2'b01: begin
        buf_d[0] = buf_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf_d[0] = cap;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = cap;
        end
      end
      default: ;
    endcase
    if (flush) cnt_d = 2'd0;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      row_q    <= '0;
      if_vld_q <= 1'b0;
      if_tag_q <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      cnt_q    <= '0;
      sclr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      row_q    <= row_d;
      if_vld_q <= if_vld_d;
      if_tag_q <= if_tag_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      sclr_q   <= sclr_d;
    end
  end

  assign ff_sclr      = sclr_q;
  assign out_valid    = (cnt_q != 2'd0);
  assign out_data     = buf_q[0].data;
  assign out_comp     = buf_q[0].tag.comp;
  assign out_blk      = buf_q[0].tag.blk;
  assign out_row      = buf_q[0].tag.row;
  assign out_mcu_last = buf_q[0].tag.last;
  assign busy         = (state_q != S_IDLE) | if_vld_q | out_valid;

endmodule

// File: tb/tb_ic_rgbtoycbcr_mcu_sched.sv
module tb_ic_rgbtoycbcr_mcu_sched;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic aclr = 1'b1, enable = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic y_empty = 1'b1, cb_empty = 1'b1, cr_empty = 1'b1;
  logic [DW-1:0] y_q = '0, cb_q = '0, cr_q = '0;
  logic y_rdreq, cb_rdreq, cr_rdreq, ff_sclr, out_valid, out_mcu_last, busy;
  logic [DW-1:0] out_data;
  logic [1:0] out_comp, out_blk;
  logic [2:0] out_row;

  always #5 clock = ~clock;

  ic_rgbtoycbcr_mcu_sched dut (
    .clock(clock), .aclr(aclr), .enable(enable), .flush(flush),
    .y_empty(y_empty), .y_rdreq(y_rdreq), .y_q(y_q),
    .cb_empty(cb_empty), .cb_rdreq(cb_rdreq), .cb_q(cb_q),
    .cr_empty(cr_empty), .cr_rdreq(cr_rdreq), .cr_q(cr_q),
    .ff_sclr(ff_sclr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_comp(out_comp), .out_blk(out_blk),
    .out_row(out_row), .out_mcu_last(out_mcu_last), .busy(busy)
  );

  // FIFO contents (what the DUT will read) and the scoreboard copy per component
  logic [DW-1:0] yq[$], cbq[$], crq[$];
  logic [DW-1:0] ye[$], cbe[$], cre[$];

  int errors = 0, checks = 0;
  int k = 0, hs_cnt = 0, outs = 0, cyc = 0;
  int first_rd = -1, first_ov = -1, last_hs_cyc = 0;
  int y_rd_n = 0, cbcr_rd_n = 0, rd_n = 0;
  logic pv_stall = 1'b0;
  logic [71:0] prev = '0;
  logic rec_y, rec_cb, rec_cr, rec_sclr;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      case (c)
        0:       begin yq.push_back(d);  ye.push_back(d);  end
        1:       begin cbq.push_back(d); cbe.push_back(d); end
        default: begin crq.push_back(d); cre.push_back(d); end
      endcase
    end
  endtask

  task automatic push_mcu();
    push(0, 32); push(1, 8); push(2, 8);
  endtask

  task automatic clr_model();
    ye.delete(); cbe.delete(); cre.delete();
    k = 0; outs = 0; pv_stall = 1'b0;
  endtask

  // One clock cycle: called at the falling edge with inputs already set.
  task automatic tick();
    int ec, eb, er;
    logic el, und;
    logic [DW-1:0] ed;
    y_empty  = (yq.size() == 0);
    cb_empty = (cbq.size() == 0);
    cr_empty = (crq.size() == 0);
    #1;
    rec_y = y_rdreq; rec_cb = cb_rdreq; rec_cr = cr_rdreq; rec_sclr = ff_sclr;
    if (y_rdreq) y_rd_n++;
    if (cb_rdreq | cr_rdreq) cbcr_rd_n++;
    if (y_rdreq | cb_rdreq | cr_rdreq) rd_n++;
    if (first_rd < 0 && y_rdreq) first_rd = cyc;
    if (first_ov < 0 && out_valid) first_ov = cyc;
    if ((y_rdreq && y_empty) || (cb_rdreq && cb_empty) || (cr_rdreq && cr_empty))
      chk("rd_when_empty", 96'(1), 96'(0));
    chk("rd_onehot", 96'($countones({y_rdreq, cb_rdreq, cr_rdreq}) <= 1), 96'(1));
    if (pv_stall)
      chk("stall_hold", 96'({out_valid, out_data, out_comp, out_blk, out_row, out_mcu_last}),
          96'({1'b1, prev}));
    if (flush) begin
      clr_model();
    end else begin
      if (out_valid && out_ready) begin
        // MCU order: 32 Y words (4 blocks x 8 rows), 8 Cb, 8 Cr
        if (k < 32)      begin ec = 0; eb = k / 8; er = k % 8; end
        else if (k < 40) begin ec = 1; eb = 0; er = k - 32; end
        else             begin ec = 2; eb = 0; er = k - 40; end
        el = (k == 47);
        und = 1'b0; ed = '0;
        case (ec)
          0: if (ye.size() > 0) ed = ye.pop_front(); else und = 1'b1;
          1: if (cbe.size() > 0) ed = cbe.pop_front(); else und = 1'b1;
          default: if (cre.size() > 0) ed = cre.pop_front(); else und = 1'b1;
        endcase
        if (und) chk("unexpected_word", 96'(1), 96'(0));
        else chk("word", 96'({out_comp, out_blk, out_row, out_mcu_last, out_data}),
                 96'({2'(ec), 2'(eb), 3'(er), el, ed}));
        k = (k + 1) % 48;
        hs_cnt++;
        last_hs_cyc = cyc;
        outs--;
      end
      if (y_rdreq | cb_rdreq | cr_rdreq) outs++;
      chk("occupancy", 96'(outs <= 2), 96'(1));
      pv_stall = out_valid & ~out_ready;
      prev = {out_data, out_comp, out_blk, out_row, out_mcu_last};
    end
    @(posedge clock); #1;
    if (rec_y  && yq.size()  > 0) y_q  = yq.pop_front();
    if (rec_cb && cbq.size() > 0) cb_q = cbq.pop_front();
    if (rec_cr && crq.size() > 0) cr_q = crq.pop_front();
    if (rec_sclr) begin yq.delete(); cbq.delete(); crq.delete(); end
    cyc++;
    @(negedge clock);
  endtask

  task automatic set_ready(input int mode);
    if (mode == 0) out_ready = 1'b1;
    else if (mode == 1) out_ready = (cyc % 2 == 0);
    else out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_mcu();
    enable = 1'b1; tick(); enable = 1'b0;
  endtask

  task automatic run_words(input int n, input int mode);
    int tgt, budget;
    tgt = hs_cnt + n; budget = 2000;
    while (hs_cnt < tgt && budget > 0) begin set_ready(mode); tick(); budget--; end
    chk("words_done", 96'(hs_cnt), 96'(tgt));
  endtask

  initial begin
    int base, budget, c;
    int ny, ncb, ncr;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("reset_outs", 96'({y_rdreq, cb_rdreq, cr_rdreq, ff_sclr, out_valid, out_data,
                          out_comp, out_blk, out_row, out_mcu_last, busy}), 96'(0));
    aclr = 1'b0;
    @(negedge clock);

    // 1) full MCU, ready always high
    push_mcu();
    first_rd = -1; first_ov = -1;
    start_mcu();
    run_words(48, 0);
    chk("first_latency", 96'(first_ov - first_rd), 96'(2));
    chk("burst_len", 96'(last_hs_cyc - first_ov), 96'(47));
    repeat (3) tick();
    chk("idle_busy_t1", 96'(busy), 96'(0));

    // 2) ready toggling
    push_mcu();
    start_mcu();
    run_words(48, 1);
    repeat (3) tick();

    // 3) Y starvation after 5 words
    push(0, 5); push(1, 8); push(2, 8);
    out_ready = 1'b1;
    base = hs_cnt; y_rd_n = 0; cbcr_rd_n = 0;
    start_mcu();
    repeat (20) tick();
    chk("stall_y_reads", 96'(y_rd_n), 96'(5));
    chk("stall_cbcr_reads", 96'(cbcr_rd_n), 96'(0));
    chk("stall_words", 96'(hs_cnt - base), 96'(5));
    chk("stall_busy", 96'({busy, out_valid}), 96'(2'b10));
    push(0, 27);
    run_words(43, 2);
    repeat (3) tick();

    // 4) flush in the middle of Cb (next word out would be Cb row 3)
    push_mcu();
    start_mcu();
    budget = 500;
    while (k != 35 && budget > 0) begin set_ready(2); tick(); budget--; end
    chk("reach_cb3", 96'(k), 96'(35));
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush_next", 96'({ff_sclr, out_valid, busy}), 96'(3'b100));
    tick();
    chk("sclr_one_cycle", 96'(ff_sclr), 96'(0));
    // flush held: sclr stays, FSM stays idle despite enable
    flush = 1'b1; enable = 1'b1; rd_n = 0;
    repeat (3) tick();
    chk("flush_hold", 96'({ff_sclr, busy}), 96'(2'b10));
    flush = 1'b0; enable = 1'b0;
    repeat (2) tick();
    chk("flush_hold_reads", 96'(rd_n), 96'(0));
    push_mcu();
    start_mcu();
    run_words(48, 2);
    repeat (3) tick();

    // 5) trickle-fed FIFOs, random ready, enable dropped at word 10
    base = hs_cnt; ny = 32; ncb = 8; ncr = 8; budget = 3000;
    enable = 1'b1;
    while (hs_cnt < base + 48 && budget > 0) begin
      if ($urandom_range(0, 3) != 0) begin
        c = $urandom_range(0, 2);
        if (c == 0 && ny > 0 && yq.size() < 16) begin push(0, 1); ny--; end
        if (c == 1 && ncb > 0 && cbq.size() < 16) begin push(1, 1); ncb--; end
        if (c == 2 && ncr > 0 && crq.size() < 16) begin push(2, 1); ncr--; end
      end
      if (hs_cnt >= base + 10) enable = 1'b0;
      set_ready(2);
      tick();
      budget--;
    end
    enable = 1'b0;
    chk("trickle_words", 96'(hs_cnt - base), 96'(48));
    out_ready = 1'b1; rd_n = 0;
    repeat (20) tick();
    chk("after_mcu_reads", 96'(rd_n), 96'(0));
    chk("after_mcu_busy", 96'(busy), 96'(0));

    // 6) async reset with words buffered
    push_mcu();
    start_mcu();
    out_ready = 1'b0;
    repeat (6) tick();
    chk("pre_aclr_valid", 96'(out_valid), 96'(1));
    aclr = 1'b1;
    #1;
    chk("aclr_outs", 96'({y_rdreq, cb_rdreq, cr_rdreq, ff_sclr, out_valid, out_data,
                         out_comp, out_blk, out_row, out_mcu_last, busy}), 96'(0));
    @(negedge clock);
    aclr = 1'b0;
    clr_model();
    out_ready = 1'b1; rd_n = 0;
    repeat (10) tick();
    chk("post_aclr_idle", 96'({busy, 31'(rd_n)}), 96'(0));
    flush = 1'b1; tick(); flush = 1'b0; tick();
    push_mcu();
    start_mcu();
    run_words(48, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
